// File: rtl/bp_cce_lce_req_rx.sv
// CCE intake for LCE request messages: ready/valid in, decode and legality check, FIFO, valid/yumi out.
// Optional per-class counters on stat_o are built only when BP_CCE_REQ_RX_STATS_EN is defined.

module bp_cce_lce_req_rx_chk
  (input  logic clk_i
  ,input  logic reset_n_i
  ,input  logic req_v_i
  ,input  logic req_yumi_i
  );

  yumi_needs_valid: assert property (@(posedge clk_i) disable iff (!reset_n_i) req_yumi_i |-> req_v_i);

endmodule

module bp_cce_lce_req_rx
  #(parameter int          paddr_width_p     = 40
   ,parameter int          lce_id_width_p    = 4
   ,parameter int          cce_id_width_p    = 4
   ,parameter int          lce_assoc_p       = 8
   ,parameter int          cce_block_width_p = 512
   ,parameter int          dword_width_p     = 64
   ,parameter int          els_p             = 2
   ,parameter logic [2:0]  block_size_e_p    = 3'd6
   ,parameter int          lru_width_lp      = $clog2(lce_assoc_p)
   ,parameter int          header_width_lp   = 4 + 4 + paddr_width_p + 3 + cce_id_width_p
                                               + lce_id_width_p + lru_width_lp + 1
   ,parameter int          msg_width_lp      = header_width_lp + cce_block_width_p
   )
  (input  logic                          clk_i
  ,input  logic                          reset_n_i
  ,input  logic [cce_id_width_p-1:0]     cce_id_i
  ,input  logic [msg_width_lp-1:0]       lce_req_i
  ,input  logic                          lce_req_v_i
  ,output logic                          lce_req_ready_o
  ,output logic [header_width_lp-1:0]    req_header_o
  ,output logic [dword_width_p-1:0]      req_data_o
  ,output logic [1:0]                    req_class_o
  ,output logic                          req_v_o
  ,input  logic                          req_yumi_i
  ,output logic                          err_o
  ,output logic [paddr_width_p-1:0]      err_addr_o
  ,output logic [63:0]                   stat_o
  );

  typedef struct packed {
    logic                      non_exclusive;
    logic [lru_width_lp-1:0]   lru_way_id;
    logic [lce_id_width_p-1:0] src_id;
    logic [cce_id_width_p-1:0] dst_id;
    logic [2:0]                size;
    logic [paddr_width_p-1:0]  addr;
    logic [3:0]                subop;
    logic [3:0]                msg_type;
  } hdr_t;

  typedef enum logic [1:0] {
    e_init     = 2'd0,
    e_run      = 2'd1,
    e_err_seen = 2'd2
  } state_e;

  localparam int ptr_w_lp   = $clog2(els_p);
  localparam int cnt_w_lp   = $clog2(els_p + 1);
  localparam int entry_w_lp = 2 + header_width_lp + dword_width_p;
  localparam logic [cnt_w_lp-1:0] els_lp     = cnt_w_lp'(els_p);
  localparam logic [cnt_w_lp-1:0] cnt_one_lp = cnt_w_lp'(1);
  localparam logic [ptr_w_lp-1:0] ptr_one_lp = ptr_w_lp'(1);
  localparam logic [ptr_w_lp-1:0] ptr_max_lp = ptr_w_lp'(els_p - 1);

  function automatic logic [ptr_w_lp-1:0] ptr_inc(input logic [ptr_w_lp-1:0] p);
    if (p == ptr_max_lp) begin
      ptr_inc = '0;
    end else begin
      ptr_inc = p + ptr_one_lp;
    end
  endfunction

  hdr_t                      in_hdr_s;
  logic [dword_width_p-1:0]  in_dword_s;
  logic                      unused_s;
  logic [1:0]                cls_s;
  logic                      type_ok_s;
  logic                      legal_s;
  logic                      hs_s, enq_s, bad_s, deq_s;

  state_e                    state_q, state_d;
  logic [cnt_w_lp-1:0]       count_q, count_d;
  logic [ptr_w_lp-1:0]       wptr_q, wptr_d, rptr_q, rptr_d;
  logic                      ready_q, ready_d;
  logic                      v_q, v_d;
  logic                      err_q, err_d;
  logic [paddr_width_p-1:0]  err_addr_q, err_addr_d;
  logic [entry_w_lp-1:0]     mem_q [els_p];
  logic [entry_w_lp-1:0]     head_s;

  assign in_hdr_s   = hdr_t'(lce_req_i[header_width_lp-1:0]);
  assign in_dword_s = lce_req_i[header_width_lp +: dword_width_p];
  // Only the low dword of the block is ever needed downstream.
  assign unused_s   = ^lce_req_i[msg_width_lp-1:header_width_lp+dword_width_p];

  // Classify the incoming message and check its legality.
  always_comb begin
    cls_s     = 2'd0;
    type_ok_s = 1'b0;
    case (in_hdr_s.msg_type)
      4'd0: begin cls_s = 2'd0; type_ok_s = (in_hdr_s.size == block_size_e_p); end
      4'd1: begin cls_s = 2'd1; type_ok_s = (in_hdr_s.size == block_size_e_p); end
      4'd2: begin cls_s = 2'd2; type_ok_s = (in_hdr_s.size <= 3'd3); end
      4'd3: begin cls_s = 2'd3; type_ok_s = (in_hdr_s.size <= 3'd3); end
      default: begin cls_s = 2'd0; type_ok_s = 1'b0; end
    endcase
  end

  assign legal_s = type_ok_s & (in_hdr_s.dst_id == cce_id_i);
  assign hs_s    = lce_req_v_i & ready_q;
  assign enq_s   = hs_s & legal_s;
  assign bad_s   = hs_s & ~legal_s;
  assign deq_s   = req_yumi_i & v_q;

  // Next-state for the FSM, FIFO bookkeeping and registered outputs.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    err_d      = err_q | bad_s;
    err_addr_d = err_addr_q;
    case (state_q)
      e_init:     state_d = e_run;
      e_run:      if (bad_s) state_d = e_err_seen; else state_d = e_run;
      e_err_seen: state_d = e_err_seen;
      default:    state_d = e_init;
    endcase
    if (enq_s & ~deq_s) begin
      count_d = count_q + cnt_one_lp;
    end else if (~enq_s & deq_s) begin
      count_d = count_q - cnt_one_lp;
    end else begin
      count_d = count_q;
    end
    if (enq_s) wptr_d = ptr_inc(wptr_q); else wptr_d = wptr_q;
    if (deq_s) rptr_d = ptr_inc(rptr_q); else rptr_d = rptr_q;
    // Only the first illegal address is kept.
    if (bad_s & ~err_q) err_addr_d = in_hdr_s.addr; else err_addr_d = err_addr_q;
    ready_d = (state_d != e_init) & (count_d < els_lp);
    v_d     = (count_d != '0);
  end

  // FSM state, FIFO pointers and registered status outputs.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q    <= e_init;
      count_q    <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      ready_q    <= 1'b0;
      v_q        <= 1'b0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      ready_q    <= ready_d;
      v_q        <= v_d;
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
    end
  end

  // Entry storage: decoded class, header and low dword per slot.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < els_p; i++) mem_q[i] <= '0;
    end else if (enq_s) begin
      mem_q[wptr_q] <= {cls_s, in_hdr_s, in_dword_s};
    end
  end

  assign head_s          = mem_q[rptr_q];
  assign req_class_o     = head_s[entry_w_lp-1 -: 2];
  assign req_header_o    = head_s[dword_width_p +: header_width_lp];
  assign req_data_o      = head_s[dword_width_p-1:0];
  assign req_v_o         = v_q;
  assign lce_req_ready_o = ready_q;
  assign err_o           = err_q;
  assign err_addr_o      = err_addr_q;

`ifdef BP_CCE_REQ_RX_STATS_EN
  logic [15:0] stat_q [4];

  // Saturating per-class counters of legal enqueues.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int k = 0; k < 4; k++) stat_q[k] <= 16'd0;
    end else if (enq_s && (stat_q[cls_s] != 16'hFFFF)) begin
      stat_q[cls_s] <= stat_q[cls_s] + 16'd1;
    end
  end

  assign stat_o = {stat_q[3], stat_q[2], stat_q[1], stat_q[0]};
`else
  assign stat_o = 64'd0;
`endif

  bp_cce_lce_req_rx_chk chk
    (.clk_i      (clk_i)
    ,.reset_n_i  (reset_n_i)
    ,.req_v_i    (v_q)
    ,.req_yumi_i (req_yumi_i)
    );

endmodule

// File: tb/tb_bp_cce_lce_req_rx.sv
// Directed plus randomized bench for bp_cce_lce_req_rx against a queue-based reference model.
module tb_bp_cce_lce_req_rx;

  localparam int PADDR = 40, LCEW = 4, CCEW = 4, ASSOC = 8, BLK = 512, DW = 64, ELS = 2;
  localparam int HW = 4 + 4 + PADDR + 3 + CCEW + LCEW + 3 + 1;
  localparam int MW = HW + BLK;
  localparam int A_LSB = 8, SZ_LSB = 8 + PADDR, DST_LSB = SZ_LSB + 3;
  localparam logic [3:0] CCE_ID = 4'h5;

  logic            clk_i = 1'b0;
  logic            reset_n_i;
  logic [CCEW-1:0] cce_id_i;
  logic [MW-1:0]   lce_req_i;
  logic            lce_req_v_i, lce_req_ready_o;
  logic [HW-1:0]   req_header_o;
  logic [DW-1:0]   req_data_o;
  logic [1:0]      req_class_o;
  logic            req_v_o, req_yumi_i, err_o;
  logic [PADDR-1:0] err_addr_o;
  logic [63:0]     stat_o;

  always #5 clk_i = ~clk_i;

  bp_cce_lce_req_rx #(.paddr_width_p(PADDR), .lce_id_width_p(LCEW), .cce_id_width_p(CCEW),
                      .lce_assoc_p(ASSOC), .cce_block_width_p(BLK), .dword_width_p(DW),
                      .els_p(ELS)) dut
    (.clk_i(clk_i), .reset_n_i(reset_n_i), .cce_id_i(cce_id_i), .lce_req_i(lce_req_i),
     .lce_req_v_i(lce_req_v_i), .lce_req_ready_o(lce_req_ready_o), .req_header_o(req_header_o),
     .req_data_o(req_data_o), .req_class_o(req_class_o), .req_v_o(req_v_o),
     .req_yumi_i(req_yumi_i), .err_o(err_o), .err_addr_o(err_addr_o), .stat_o(stat_o));

  typedef struct { logic [1:0] cls; logic [HW-1:0] hdr; logic [DW-1:0] data; } ent_t;
  ent_t            mq[$];
  logic [15:0]     m_cnt [4];
  bit              m_init, m_err;
  logic [PADDR-1:0] m_err_addr;
  int              vectors = 0, miscompares = 0;

  function automatic logic [MW-1:0] mk(input logic [3:0] t, input logic [2:0] sz,
                                       input logic [PADDR-1:0] a, input logic [3:0] dst,
                                       input logic [DW-1:0] d);
    logic [HW-1:0]  h;
    logic [BLK-1:0] blk;
    h = {1'b0, 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), dst, sz, a, 4'd0, t};
    blk = '0;
    blk[DW-1:0] = d;
    blk[BLK-1 -: 32] = 32'($urandom);
    return {blk, h};
  endfunction

  function automatic logic [MW-1:0] rand_legal();
    logic [3:0] t;
    t = 4'($urandom_range(0, 3));
    return mk(t, (t < 4'd2) ? 3'd6 : 3'($urandom_range(0, 3)),
              {8'h00, 32'($urandom)}, CCE_ID, {32'($urandom), 32'($urandom)});
  endfunction

  // Spec rules: right destination, cached needs 64B, uncached at most 8B, defined type.
  function automatic bit legal(input logic [HW-1:0] h);
    logic [3:0] t;
    logic [2:0] sz;
    t  = h[3:0];
    sz = h[SZ_LSB +: 3];
    if (h[DST_LSB +: 4] != CCE_ID) return 1'b0;
    if (t == 4'd0 || t == 4'd1) return sz == 3'd6;
    if (t == 4'd2 || t == 4'd3) return sz <= 3'd3;
    return 1'b0;
  endfunction

  function automatic logic [63:0] exp_stat();
`ifdef BP_CCE_REQ_RX_STATS_EN
    return {m_cnt[3], m_cnt[2], m_cnt[1], m_cnt[0]};
`else
    return 64'd0;
`endif
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("ready", 128'(lce_req_ready_o), 128'(!m_init && (mq.size() < ELS)));
    chk("req_v", 128'(req_v_o), 128'(mq.size() != 0));
    chk("err", 128'(err_o), 128'(m_err));
    chk("err_addr", 128'(err_addr_o), 128'(m_err_addr));
    chk("stat", 128'(stat_o), 128'(exp_stat()));
    if (mq.size() != 0) begin
      chk("class", 128'(req_class_o), 128'(mq[0].cls));
      chk("header", 128'(req_header_o), 128'(mq[0].hdr));
      if (mq[0].cls == 2'd3) chk("uc_data", 128'(req_data_o), 128'(mq[0].data));
    end
  endtask

  // One clock: check at the falling edge, drive, then advance the model past the rising edge.
  task automatic cyc(input bit v, input logic [MW-1:0] m, input bit y);
    bit            hs, yy;
    logic [HW-1:0] h;
    ent_t          e;
    check_all();
    yy = y && (mq.size() != 0);
    hs = v && !m_init && (mq.size() < ELS);
    lce_req_v_i = v;
    lce_req_i   = m;
    req_yumi_i  = yy;
    h = m[HW-1:0];
    @(posedge clk_i);
    if (yy) void'(mq.pop_front());
    if (hs) begin
      if (legal(h)) begin
        e.cls = h[1:0]; e.hdr = h; e.data = m[HW +: DW];
        mq.push_back(e);
        if (m_cnt[h[1:0]] != 16'hFFFF) m_cnt[h[1:0]] = m_cnt[h[1:0]] + 16'd1;
      end else if (!m_err) begin
        m_err = 1'b1;
        m_err_addr = h[A_LSB +: PADDR];
      end
    end
    m_init = 1'b0;
    @(negedge clk_i);
  endtask

  task automatic do_reset();
    reset_n_i = 1'b0;
    lce_req_v_i = 1'b0;
    req_yumi_i = 1'b0;
    mq.delete();
    m_init = 1'b1; m_err = 1'b0; m_err_addr = '0;
    for (int k = 0; k < 4; k++) m_cnt[k] = 16'd0;
    #1;
    check_all();
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    reset_n_i = 1'b1;
  endtask

  initial begin
    logic [MW-1:0] a, b, c;
    logic [3:0]    t;
    logic [2:0]    sz;
    reset_n_i = 1'b1; cce_id_i = CCE_ID; lce_req_i = '0; lce_req_v_i = 1'b0; req_yumi_i = 1'b0;
    @(negedge clk_i);
    do_reset();

    // Single cached read: init cycle refuses, next cycle accepts, visible one cycle later.
    a = mk(4'd0, 3'd6, 40'h00_8000_0040, CCE_ID, 64'h1);
    cyc(1'b1, a, 1'b0);
    cyc(1'b1, a, 1'b0);
    cyc(1'b0, '0, 1'b1);
    cyc(1'b0, '0, 1'b0);

    // Fill two entries; third waits for a yumi and order is preserved.
    a = mk(4'd1, 3'd6, 40'h00_0000_0A00, CCE_ID, 64'hA);
    b = mk(4'd0, 3'd6, 40'h00_0000_0B00, CCE_ID, 64'hB);
    c = mk(4'd2, 3'd3, 40'h00_0000_0C00, CCE_ID, 64'hC);
    cyc(1'b1, a, 1'b0);
    cyc(1'b1, b, 1'b0);
    cyc(1'b1, c, 1'b0);
    cyc(1'b1, c, 1'b1);
    cyc(1'b1, c, 1'b0);
    repeat (3) cyc(1'b0, '0, 1'b1);

    // Streaming at occupancy one, wrapping the pointers several times.
    cyc(1'b1, rand_legal(), 1'b0);
    for (int i = 0; i < 10; i++) cyc(1'b1, rand_legal(), 1'b1);
    repeat (2) cyc(1'b0, '0, 1'b1);

    // Uncached write carries its data dword.
    cyc(1'b1, mk(4'd3, 3'd2, 40'h00_0000_3000, CCE_ID, 64'h0000_0000_DEAD_BEEF), 1'b0);
    cyc(1'b0, '0, 1'b1);
    cyc(1'b0, '0, 1'b0);

    // Two illegal messages; only the first address is latched, later traffic still flows.
    cyc(1'b1, mk(4'd1, 3'd3, 40'h00_0000_1000, CCE_ID, 64'h0), 1'b0);
    cyc(1'b1, mk(4'd0, 3'd6, 40'h00_0000_2000, 4'hA, 64'h0), 1'b0);
    cyc(1'b1, rand_legal(), 1'b0);
    cyc(1'b0, '0, 1'b1);
    cyc(1'b0, '0, 1'b0);

    // Random traffic including illegal sizes, types and destinations.
    for (int i = 0; i < 80; i++) begin
      t  = 4'($urandom_range(0, 5));
      sz = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7))
         : ((t < 4'd2) ? 3'd6 : 3'($urandom_range(0, 3)));
      cyc($urandom_range(0, 3) != 0,
          mk(t, sz, {8'h00, 32'($urandom)}, ($urandom_range(0, 7) == 0) ? 4'h3 : CCE_ID,
             {32'($urandom), 32'($urandom)}),
          $urandom_range(0, 1) == 1);
    end

    // Class counting after a clean reset: 3 rd, 2 wr, 1 uc rd, 1 illegal.
    do_reset();
    cyc(1'b0, '0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b1, mk(4'd0, 3'd6, 40'h40 * (i + 1), CCE_ID, 64'h0), 1'b1);
    for (int i = 0; i < 2; i++) cyc(1'b1, mk(4'd1, 3'd6, 40'h1000 + i, CCE_ID, 64'h0), 1'b1);
    cyc(1'b1, mk(4'd2, 3'd1, 40'h5000, CCE_ID, 64'h0), 1'b1);
    cyc(1'b1, mk(4'd5, 3'd6, 40'h6000, CCE_ID, 64'h0), 1'b1);
    cyc(1'b0, '0, 1'b1);
    cyc(1'b0, '0, 1'b0);

    // Reset in the middle of a burst clears everything immediately.
    cyc(1'b1, rand_legal(), 1'b0);
    cyc(1'b1, rand_legal(), 1'b0);
    do_reset();
    cyc(1'b0, '0, 1'b0);
    cyc(1'b0, '0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
